// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a fixed note table on a tempo tick and drives a square-wave tone generator.
// Optional MELODY_LOOP_EN adds a loop input that restarts playback at the end marker.
module melody_sequencer #(
  parameter int unsigned TICK_DIV  = 120000,
  parameter int unsigned GAP_TICKS = 2,
  parameter int unsigned DIV_W     = 24,
  parameter int unsigned DUR_W     = 8
) (
  input  logic             clk12MHz,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
`ifdef MELODY_LOOP_EN
  input  logic             loop,
`endif
  output logic [DIV_W-1:0] half_period,
  output logic             note_on,
  output logic             note_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       index
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? DUR_W'(GAP_TICKS - 1) : '0;

  logic [2:0]       state;
  logic [PW-1:0]    presc;
  logic [DUR_W-1:0] tick_cnt;
  logic [DUR_W-1:0] dur_reg;
  logic             is_rest;
  logic             tick;
  logic             last_entry;
  logic             loop_en;

  logic             rom_rest;
  logic [DIV_W-1:0] rom_hp;
  logic [DUR_W-1:0] rom_dur;

`ifdef MELODY_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  // Entry layout {rest, half_period, duration}; duration 0 marks the end.
  always_comb begin
    rom_rest = 1'b0;
    rom_hp   = '0;
    rom_dur  = '0;
    case (index)
      4'd0: begin rom_hp = DIV_W'(13636); rom_dur = DUR_W'(25); end
      4'd1: begin rom_rest = 1'b1;        rom_dur = DUR_W'(10); end
      4'd2: begin rom_hp = DIV_W'(11467); rom_dur = DUR_W'(25); end
      4'd3: begin rom_hp = DIV_W'(9101);  rom_dur = DUR_W'(50); end
      default: ;
    endcase
  end

  assign tick       = (presc == PRE_LAST);
  assign last_entry = (index == 4'hF);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      presc       <= '0;
      tick_cnt    <= '0;
      dur_reg     <= '0;
      is_rest     <= 1'b0;
      half_period <= '0;
      note_on     <= 1'b0;
      note_valid  <= 1'b0;
      index       <= '0;
    end else begin
      note_valid <= 1'b0;
      presc      <= tick ? '0 : presc + 1'b1;
      if (stop) begin
        state   <= S_IDLE;
        note_on <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            state <= S_LOAD;
            index <= '0;
          end
          S_LOAD: begin
            if (rom_dur == '0) begin
              if (loop_en) index <= '0;
              else         state <= S_DONE;
            end else begin
              state    <= S_PLAY;
              presc    <= '0;
              tick_cnt <= '0;
              dur_reg  <= rom_dur;
              is_rest  <= rom_rest;
              note_on  <= ~rom_rest;
              if (!rom_rest) begin
                half_period <= rom_hp;
                note_valid  <= 1'b1;
              end
            end
          end
          S_PLAY: if (tick) begin
            if (tick_cnt == dur_reg - 1'b1) begin
              note_on  <= 1'b0;
              tick_cnt <= '0;
              if (!is_rest && GAP_TICKS > 0) begin
                state <= S_GAP;
                presc <= '0;
              end else begin
                // Entry 15 without an end marker ends playback instead of wrapping.
                state <= last_entry ? S_DONE : S_LOAD;
                if (!last_entry) index <= index + 4'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_GAP: if (tick) begin
            if (tick_cnt == GAP_LAST) begin
              tick_cnt <= '0;
              state    <= last_entry ? S_DONE : S_LOAD;
              if (!last_entry) index <= index + 4'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized bench for melody_sequencer: two instances (gap=1 and legato) checked against a
// per-cycle expected timeline built directly from the melody table.
module tb_melody_sequencer;
  localparam int TD = 4;

  logic clk12MHz = 1'b0;
  always #5 clk12MHz = ~clk12MHz;

  logic        rst, start_g, stop_g, start_l, stop_l;
  logic [23:0] hp_g, hp_l;
  logic        on_g, on_l, nv_g, nv_l, busy_g, busy_l, done_g, done_l;
  logic [3:0]  idx_g, idx_l;
`ifdef MELODY_LOOP_EN
  logic        loop_g = 1'b0;
  logic        loop_l = 1'b0;
`endif

  melody_sequencer #(.TICK_DIV(TD), .GAP_TICKS(1), .DIV_W(24), .DUR_W(8)) dut_g (
    .clk12MHz(clk12MHz), .rst(rst), .start(start_g), .stop(stop_g),
`ifdef MELODY_LOOP_EN
    .loop(loop_g),
`endif
    .half_period(hp_g), .note_on(on_g), .note_valid(nv_g), .busy(busy_g), .done(done_g),
    .index(idx_g));

  melody_sequencer #(.TICK_DIV(TD), .GAP_TICKS(0), .DIV_W(24), .DUR_W(8)) dut_l (
    .clk12MHz(clk12MHz), .rst(rst), .start(start_l), .stop(stop_l),
`ifdef MELODY_LOOP_EN
    .loop(loop_l),
`endif
    .half_period(hp_l), .note_on(on_l), .note_valid(nv_l), .busy(busy_l), .done(done_l),
    .index(idx_l));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Melody table as the specification lists it.
  int          dur_tab [4] = '{25, 10, 25, 50};
  logic [23:0] hp_tab  [4] = '{24'd13636, 24'd0, 24'd11467, 24'd9101};
  bit          rest_tab[4] = '{0, 1, 0, 0};

  logic [23:0] m_hp [2];
  logic [3:0]  m_idx[2];
  logic [31:0] tl[$];

  function automatic logic [31:0] pk(input logic b, input logic d, input logic on,
                                     input logic v, input logic [3:0] ix, input logic [23:0] hp);
    return {b, d, on, v, ix, hp};
  endfunction

  function automatic logic [31:0] obs(input int which);
    if (which == 1) return pk(busy_l, done_l, on_l, nv_l, idx_l, hp_l);
    return pk(busy_g, done_g, on_g, nv_g, idx_g, hp_g);
  endfunction

  // Expected outputs for every cycle after start is sampled, through the return to idle.
  task automatic build_timeline(input int gap, input logic [23:0] hp0);
    logic [23:0] hp;
    hp = hp0;
    tl.delete();
    tl.push_back(pk(1, 0, 0, 0, 4'd0, hp));
    for (int i = 0; i < 4; i++) begin
      if (!rest_tab[i]) hp = hp_tab[i];
      for (int c = 0; c < dur_tab[i] * TD; c++)
        tl.push_back(pk(1, 0, !rest_tab[i], !rest_tab[i] && c == 0, 4'(i), hp));
      if (!rest_tab[i])
        for (int c = 0; c < gap * TD; c++) tl.push_back(pk(1, 0, 0, 0, 4'(i), hp));
      tl.push_back(pk(1, 0, 0, 0, 4'(i + 1), hp));
    end
    tl.push_back(pk(1, 1, 0, 0, 4'd4, hp));
    tl.push_back(pk(0, 0, 0, 0, 4'd4, hp));
  endtask

  task automatic set_in(input int which, input logic st, input logic sp);
    if (which == 1) begin start_l = st; stop_l = sp; end
    else            begin start_g = st; stop_g = sp; end
  endtask

  task automatic idle_cycles(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk12MHz);
      check("idle", obs(which), pk(0, 0, 0, 0, m_idx[which], m_hp[which]));
    end
  endtask

  // Called at a negedge; starts playback and follows the timeline, optionally stopping at cycle stop_at.
  task automatic run_trial(input int which, input int stop_at, input bit junk);
    int nv, nd;
    logic [31:0] e, o;
    nv = 0; nd = 0;
    build_timeline(which == 1 ? 0 : 1, m_hp[which]);
    set_in(which, 1'b1, 1'b0);
    for (int k = 0; k < tl.size(); k++) begin
      @(negedge clk12MHz);
      o = obs(which);
      check("seq", o, tl[k]);
      if (o[28]) nv++;
      if (o[30]) nd++;
      set_in(which, junk && k <= tl.size() - 2 && $urandom_range(0, 15) == 0, k == stop_at);
      if (k == stop_at) begin
        @(negedge clk12MHz);
        set_in(which, 1'b0, 1'b0);
        e = tl[k];
        e[31:28] = 4'b0000;
        check("stop", obs(which), e);
        m_hp[which]  = e[23:0];
        m_idx[which] = e[27:24];
        return;
      end
    end
    set_in(which, 1'b0, 1'b0);
    check("note_valid_cnt", 32'(nv), 32'd3);
    check("done_cnt", 32'(nd), 32'd1);
    m_hp[which]  = tl[tl.size() - 1][23:0];
    m_idx[which] = 4'd4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_g = 1'b0; stop_g = 1'b0; start_l = 1'b0; stop_l = 1'b0;
    repeat (3) @(negedge clk12MHz);
    check("reset_g", obs(0), 32'd0);
    check("reset_l", obs(1), 32'd0);
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin m_hp[w] = '0; m_idx[w] = '0; end

    idle_cycles(0, 3);
    run_trial(0, -1, 1'b0);
    idle_cycles(1, 2);
    run_trial(1, -1, 1'b0);

    // stop during entry 3, then a full replay from entry 0
    idle_cycles(0, 2);
    run_trial(0, 300, 1'b0);
    check("stop_idx", 32'(idx_g), 32'd3);
    idle_cycles(0, 2);
    run_trial(0, -1, 1'b1);

    // start and stop together while idle: stop wins
    set_in(0, 1'b1, 1'b1);
    @(negedge clk12MHz);
    set_in(0, 1'b0, 1'b0);
    check("start_stop_idle", obs(0), pk(0, 0, 0, 0, m_idx[0], m_hp[0]));

    for (int t = 0; t < 10; t++) begin
      int which, stop_at;
      which   = int'($urandom_range(0, 1));
      stop_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 440));
      idle_cycles(which, int'($urandom_range(1, 5)));
      run_trial(which, stop_at, 1'b1);
    end

    // asynchronous reset in the middle of a sounding note
    idle_cycles(0, 1);
    set_in(0, 1'b1, 1'b0);
    @(negedge clk12MHz);
    set_in(0, 1'b0, 1'b0);
    repeat (20) @(negedge clk12MHz);
    check("pre_rst_note_on", 32'(on_g), 32'd1);
    @(posedge clk12MHz);
    #3 rst = 1'b1;
    #1 check("rst_async", obs(0), 32'd0);
    start_g = 1'b1;
    repeat (2) begin
      @(negedge clk12MHz);
      check("rst_hold", obs(0), 32'd0);
    end
    start_g = 1'b0;
    #2 rst = 1'b0;
    for (int w = 0; w < 2; w++) begin m_hp[w] = '0; m_idx[w] = '0; end
    idle_cycles(0, 3);
    run_trial(0, -1, 1'b0);
    idle_cycles(0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
